// File: rtl/mux_stream_collector.sv
// rtl/mux_stream_collector.sv - serial-to-parallel word collector with output FIFO
module mux_stream_collector #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     bit_in,
    input  logic                     bit_valid,
    input  logic                     clear,
    output logic [WIDTH-1:0]         word_out,
    output logic                     word_valid,
    input  logic                     word_ready,
    output logic [$clog2(DEPTH):0]   fill,
    output logic [$clog2(WIDTH):0]   bit_cnt,
    output logic                     overflow
);

    localparam int CNT_W  = $clog2(WIDTH) + 1;
    localparam int FILL_W = $clog2(DEPTH) + 1;
    localparam int PTR_W  = $clog2(DEPTH);

    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WIDTH - 1);
    localparam logic [FILL_W-1:0] FULL_FILL = FILL_W'(DEPTH);

    // Collector state: partially assembled word, LSB-first
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic             word_done;

    // FIFO storage and bookkeeping
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [FILL_W-1:0] fill_next;
    logic              full;
    logic              pop;
    logic              push;
    logic              drop;

    // Insert the incoming bit at the current position; the completed word is shift_next
    always_comb begin
        shift_next = shift_reg;
        for (int i = 0; i < WIDTH; i++) begin
            if (bit_cnt == CNT_W'(i)) begin
                shift_next[i] = bit_in;
            end
        end
        word_done = bit_valid && (bit_cnt == LAST_BIT);
    end

    // Push/pop decisions; a full FIFO still accepts a word when the head leaves on the same edge
    always_comb begin
        full      = (fill == FULL_FILL);
        pop       = word_valid && word_ready;
        push      = word_done && (!full || pop);
        drop      = word_done && full && !pop;
        fill_next = fill;
        if (push && !pop) begin
            fill_next = fill + 1'b1;
        end else if (pop && !push) begin
            fill_next = fill - 1'b1;
        end
    end

    // Bit collector: position counter and shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (clear) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (bit_valid) begin
            if (word_done) begin
                shift_reg <= '0;
                bit_cnt   <= '0;
            end else begin
                shift_reg <= shift_next;
                bit_cnt   <= bit_cnt + 1'b1;
            end
        end
    end

    // FIFO storage; entries are zeroed on flush so the head reads 0 afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= shift_next;
        end
    end

    // FIFO pointers, occupancy and registered valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fill       <= '0;
            word_valid <= 1'b0;
        end else if (clear) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fill       <= '0;
            word_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fill       <= fill_next;
            word_valid <= (fill_next != '0);
        end
    end

    // Sticky overflow flag, cleared only by reset or flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (clear) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

    // Head of the FIFO; only registered state feeds this, never word_ready
    always_comb begin
        word_out = mem[rd_ptr];
    end

endmodule

// File: tb/tb_mux_stream_collector.sv
// tb/tb_mux_stream_collector.sv - randomized self-checking bench for mux_stream_collector
module tb_mux_stream_collector;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic                   clk;
    logic                   rst_n;
    logic                   bit_in;
    logic                   bit_valid;
    logic                   clear;
    logic [WIDTH-1:0]       word_out;
    logic                   word_valid;
    logic                   word_ready;
    logic [$clog2(DEPTH):0] fill;
    logic [$clog2(WIDTH):0] bit_cnt;
    logic                   overflow;

    int checks;
    int errors;

    // Reference model: queue of words, integer bit count, partial value, sticky flag
    int m_q[$];
    int m_cnt;
    int m_part;
    bit m_ovf;

    mux_stream_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .clear(clear), .word_out(word_out), .word_valid(word_valid),
        .word_ready(word_ready), .fill(fill), .bit_cnt(bit_cnt), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_q.delete();
        m_cnt  = 0;
        m_part = 0;
        m_ovf  = 0;
    endtask

    // Drive one cycle and advance the model; returns 1 ns after the rising edge
    task automatic step(input bit bv, input bit b, input bit rdy, input bit clr);
        int  size_before;
        bit  do_pop;
        bit_valid  = bv;
        bit_in     = b;
        word_ready = rdy;
        clear      = clr;
        if (clr) begin
            model_reset();
        end else begin
            size_before = m_q.size();
            do_pop = (size_before > 0) && rdy;
            if (do_pop) void'(m_q.pop_front());
            if (bv) begin
                m_part = m_part + (int'(b) << m_cnt);
                m_cnt  = m_cnt + 1;
                if (m_cnt == WIDTH) begin
                    if (size_before < DEPTH || do_pop) m_q.push_back(m_part);
                    else m_ovf = 1;
                    m_part = 0;
                    m_cnt  = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        bit_valid  = 0;
        clear      = 0;
        word_ready = 0;
    endtask

    task automatic send_word(input int w, input bit rdy_last);
        for (int i = 0; i < WIDTH; i++) begin
            step(1'b1, w[i], (i == WIDTH - 1) ? rdy_last : 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset();
        rst_n = 0; bit_in = 0; bit_valid = 0; clear = 0; word_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", word_valid); end
        checks++; if (word_out !== 8'h00) begin errors++; $display("FAIL reset_word got %0h exp 0", word_out); end
        checks++; if (fill !== 3'd0) begin errors++; $display("FAIL reset_fill got %0d exp 0", fill); end
        checks++; if (bit_cnt !== 4'd0) begin errors++; $display("FAIL reset_bitcnt got %0d exp 0", bit_cnt); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b exp 0", overflow); end
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int bits[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
        for (int i = 0; i < 8; i++) begin
            step(1'b1, bits[i][0], 1'b0, 1'b0);
            if (i < 7) begin
                checks++; if (bit_cnt !== 4'(i + 1)) begin errors++; $display("FAIL basic_bitcnt got %0d exp %0d", bit_cnt, i + 1); end
                checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %0b exp 0", word_valid); end
            end
        end
        checks++; if (word_out !== 8'hA5) begin errors++; $display("FAIL basic_word got %0h exp a5", word_out); end
        checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b exp 1", word_valid); end
        checks++; if (fill !== 3'd1) begin errors++; $display("FAIL basic_fill got %0d exp 1", fill); end
        checks++; if (bit_cnt !== 4'd0) begin errors++; $display("FAIL basic_bitcnt_wrap got %0d exp 0", bit_cnt); end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %0b exp 0", word_valid); end
    endtask

    task automatic test_gapped();
        int bits[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
        for (int i = 0; i < 8; i++) begin
            step(1'b1, bits[i][0], 1'b0, 1'b0);
            step(1'b0, ~bits[i][0], 1'b0, 1'b0);
            if (i < 7) begin
                checks++; if (bit_cnt !== 4'(i + 1)) begin errors++; $display("FAIL gap_bitcnt_hold got %0d exp %0d", bit_cnt, i + 1); end
            end
        end
        checks++; if (word_out !== 8'hA5) begin errors++; $display("FAIL gap_word got %0h exp a5", word_out); end
        checks++; if (fill !== 3'd1) begin errors++; $display("FAIL gap_fill got %0d exp 1", fill); end
        step(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_overflow();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int w = 1; w <= 5; w++) send_word(w, 1'b0);
        checks++; if (fill !== 3'd4) begin errors++; $display("FAIL ovf_fill got %0d exp 4", fill); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b exp 1", overflow); end
        for (int w = 1; w <= 4; w++) begin
            checks++; if (word_out !== 8'(w)) begin errors++; $display("FAIL ovf_order got %0h exp %0h", word_out, w); end
            step(1'b0, 1'b0, 1'b1, 1'b0);
        end
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %0b exp 0", word_valid); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b exp 1", overflow); end
    endtask

    task automatic test_full_pop();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int w = 'h11; w <= 'h14; w++) send_word(w, 1'b0);
        send_word('h15, 1'b1);
        checks++; if (fill !== 3'd4) begin errors++; $display("FAIL fullpop_fill got %0d exp 4", fill); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_ovf got %0b exp 0", overflow); end
        for (int w = 'h12; w <= 'h15; w++) begin
            checks++; if (word_out !== 8'(w)) begin errors++; $display("FAIL fullpop_order got %0h exp %0h", word_out, w); end
            step(1'b0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_reset_mid_word();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_word('h3C, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        rst_n = 0;
        model_reset();
        #2;
        checks++; if (bit_cnt !== 4'd0) begin errors++; $display("FAIL rst_async_bitcnt got %0d exp 0", bit_cnt); end
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got %0b exp 0", word_valid); end
        checks++; if (fill !== 3'd0) begin errors++; $display("FAIL rst_async_fill got %0d exp 0", fill); end
        checks++; if (word_out !== 8'h00) begin errors++; $display("FAIL rst_async_word got %0h exp 0", word_out); end
        rst_n = 1;
        send_word('hFF, 1'b0);
        checks++; if (word_out !== 8'hFF) begin errors++; $display("FAIL rst_restart_word got %0h exp ff", word_out); end
        checks++; if (fill !== 3'd1) begin errors++; $display("FAIL rst_restart_fill got %0d exp 1", fill); end
    endtask

    task automatic test_clear();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int w = 1; w <= 5; w++) send_word(w * 7, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (fill !== 3'd2 || overflow !== 1'b1) begin errors++; $display("FAIL clear_setup got fill %0d ovf %0b exp 2 1", fill, overflow); end
        step(1'b1, 1'b1, 1'b1, 1'b1);
        checks++; if (fill !== 3'd0) begin errors++; $display("FAIL clear_fill got %0d exp 0", fill); end
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL clear_valid got %0b exp 0", word_valid); end
        checks++; if (bit_cnt !== 4'd0) begin errors++; $display("FAIL clear_bitcnt got %0d exp 0", bit_cnt); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clear_ovf got %0b exp 0", overflow); end
        checks++; if (word_out !== 8'h00) begin errors++; $display("FAIL clear_word got %0h exp 0", word_out); end
    endtask

    task automatic test_random();
        int rdy_pct;
        for (int c = 0; c < 1500; c++) begin
            rdy_pct = ((c / 100) % 3 == 0) ? 10 : ((c / 100) % 3 == 1) ? 50 : 90;
            step($urandom_range(0, 99) < 80, 1'($urandom), $urandom_range(0, 99) < rdy_pct,
                 $urandom_range(0, 199) == 0);
            checks++; if (fill !== 3'(m_q.size())) begin errors++; $display("FAIL rnd_fill cyc %0d got %0d exp %0d", c, fill, m_q.size()); end
            checks++; if (word_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL rnd_valid cyc %0d got %0b", c, word_valid); end
            checks++; if (bit_cnt !== 4'(m_cnt)) begin errors++; $display("FAIL rnd_bitcnt cyc %0d got %0d exp %0d", c, bit_cnt, m_cnt); end
            checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf cyc %0d got %0b exp %0b", c, overflow, m_ovf); end
            if (m_q.size() != 0) begin
                checks++; if (word_out !== 8'(m_q[0])) begin errors++; $display("FAIL rnd_word cyc %0d got %0h exp %0h", c, word_out, m_q[0]); end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_gapped();
        test_overflow();
        test_full_pop();
        test_reset_mid_word();
        test_clear();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
